// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared types and constants for the serial arithmetic blocks
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int N_DEF = 4;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - 1-bit combinational subtractor cell
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_sub_nbit.sv
// rtl/serial_sub_nbit.sv - bit-serial N-bit subtractor, LSB first, start/done handshake
module serial_sub_nbit
  import serial_arith_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] d,
  output logic         bout
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  ra_q, ra_d;
  logic [N-1:0]  rb_q, rb_d;
  logic [N-1:0]  res_q, res_d;
  logic [N-1:0]  d_q, d_d;
  logic          brw_q, brw_d;
  logic          bout_q, bout_d;

  logic          fs_d;
  logic          fs_bout;
  logic          accept;
  logic          last;
  logic [N-1:0]  res_shift;

  full_subtractor u_fs (
    .a    (ra_q[0]),
    .b    (rb_q[0]),
    .bin  (brw_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      res_q   <= '0;
      d_q     <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      res_q   <= res_d;
      d_q     <= d_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CW'(N - 1)) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Start is only honoured outside SHIFT, so an in-flight operation is never disturbed.
  always_comb begin
    accept    = start && (state_q != SHIFT);
    last      = (state_q == SHIFT) && (cnt_q == CW'(N - 1));
    res_shift = (res_q >> 1) | (N'(fs_d) << (N - 1));

    cnt_d  = cnt_q;
    ra_d   = ra_q;
    rb_d   = rb_q;
    res_d  = res_q;
    brw_d  = brw_q;
    d_d    = d_q;
    bout_d = bout_q;

    if (accept) begin
      ra_d  = a;
      rb_d  = b;
      brw_d = bin;
      res_d = '0;
      cnt_d = '0;
    end else if (state_q == SHIFT) begin
      ra_d  = ra_q >> 1;
      rb_d  = rb_q >> 1;
      brw_d = fs_bout;
      res_d = res_shift;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        d_d    = res_shift;
        bout_d = fs_bout;
      end
    end
  end

  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
    d    = d_q;
    bout = bout_q;
  end

endmodule
